// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared synth widths, midscale and LFSR constants
package synth_pkg;

  localparam int NBIT_DATA = 6;
  localparam int NBIT_OSC  = 8;
  localparam int NBIT_PWM  = 8;

  localparam int MIDSCALE_PWM = 2 ** (NBIT_PWM - 1);

  // x^8+x^6+x^5+x^4+1 as a Fibonacci tap mask on bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr8_next(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM period counter, capture/compute decode, duty register and comparator
module pwm_gen
  import synth_pkg::*;
#(
  parameter int nbit_pwm = NBIT_PWM
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [nbit_pwm-1:0] duty_next,
  output logic                capture,
  output logic                compute,
  output logic [nbit_pwm-1:0] duty_active,
  output logic                pwm_out
);

  localparam logic [nbit_pwm-1:0] CNT_MAX = '1;
  localparam logic [nbit_pwm-1:0] MID     = {1'b1, {(nbit_pwm-1){1'b0}}};

  logic [nbit_pwm-1:0] cnt;

  assign capture = (cnt == CNT_MAX);
  assign compute = (cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      duty_active <= MID;
      pwm_out     <= 1'b0;
    end else begin
      cnt     <= cnt + 1'b1;
      // Compares against the old duty on the capture edge, so each period is whole
      pwm_out <= (cnt < duty_active);
      if (capture) begin
        duty_active <= duty_next;
      end
    end
  end

endmodule

// File: rtl/vca_pwm.sv
// rtl/vca_pwm.sv - envelope-scaled oscillator to PWM output stage; VCA_DITHER_EN adds LFSR dither
module vca_pwm
  import synth_pkg::*;
#(
  parameter int nbit_data = NBIT_DATA,
  parameter int nbit_osc  = NBIT_OSC,
  parameter int nbit_pwm  = NBIT_PWM
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [nbit_osc-1:0]  osc_in,
  input  logic [nbit_data-1:0] env_in,
  input  logic                 env_valid,
  output logic                 sample_tick,
  output logic [nbit_pwm-1:0]  duty_out,
  output logic                 pwm_out
);

  localparam int PW = nbit_osc + nbit_data + 1;
  localparam int SH = nbit_osc + nbit_data - nbit_pwm;

  localparam logic signed [PW-1:0] MID_OSC_X = PW'(2 ** (nbit_osc - 1));
  localparam logic signed [PW:0]   MID_PWM_X = (PW + 1)'(2 ** (nbit_pwm - 1));
  localparam logic signed [PW:0]   MAX_PWM_X = (PW + 1)'(2 ** nbit_pwm - 1);
  localparam logic [nbit_pwm-1:0]  MID       = {1'b1, {(nbit_pwm-1){1'b0}}};

  logic                 capture;
  logic                 compute;
  logic [nbit_osc-1:0]  osc_q;
  logic [nbit_data-1:0] env_q;
  logic [nbit_pwm-1:0]  duty_next;
  logic [nbit_pwm-1:0]  duty_active;
  logic [nbit_pwm-1:0]  duty_sat;
  logic signed [PW-1:0] s_ext;
  logic signed [PW-1:0] e_ext;
  logic signed [PW-1:0] p;
  logic signed [PW-1:0] p_sh;
  logic signed [PW:0]   sum;
  logic                 dither;

  pwm_gen #(
    .nbit_pwm(nbit_pwm)
  ) u_pwm_gen (
    .clk        (clk),
    .rstn       (rstn),
    .duty_next  (duty_next),
    .capture    (capture),
    .compute    (compute),
    .duty_active(duty_active),
    .pwm_out    (pwm_out)
  );

  assign sample_tick = capture;
  assign duty_out    = duty_active;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      osc_q <= '0;
      env_q <= '0;
    end else if (capture) begin
      osc_q <= osc_in;
      env_q <= env_valid ? env_in : '0;
    end
  end

  // Operands widened to PW bits so the truncated product is exact for any envelope level
  always_comb begin
    s_ext = $signed({{(PW-nbit_osc){1'b0}}, osc_q}) - MID_OSC_X;
    e_ext = $signed({{(PW-nbit_data){1'b0}}, env_q});
    p     = s_ext * e_ext;
    p_sh  = p >>> SH;
    sum   = $signed({p_sh[PW-1], p_sh}) + MID_PWM_X + $signed({{PW{1'b0}}, dither});
    if (sum[PW]) begin
      duty_sat = '0;
    end else if (sum > MAX_PWM_X) begin
      duty_sat = '1;
    end else begin
      duty_sat = sum[nbit_pwm-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_next <= MID;
    end else if (compute) begin
      duty_next <= duty_sat;
    end
  end

`ifdef VCA_DITHER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr <= LFSR_SEED;
    end else if (compute) begin
      lfsr <= lfsr8_next(lfsr);
    end
  end

  assign dither = lfsr[0];
`else
  assign dither = 1'b0;
`endif

endmodule

// File: tb/tb_vca_pwm.sv
// tb/tb_vca_pwm.sv - scoreboard bench for vca_pwm per-period duty, pulse width and tick
module tb_vca_pwm;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] osc_in;
  logic [5:0] env_in;
  logic       env_valid;
  logic       sample_tick;
  logic [7:0] duty_out;
  logic       pwm_out;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int lfsr_m;

  always #5 clk = ~clk;

  vca_pwm dut (
    .clk        (clk),
    .rstn       (rstn),
    .osc_in     (osc_in),
    .env_in     (env_in),
    .env_valid  (env_valid),
    .sample_tick(sample_tick),
    .duty_out   (duty_out),
    .pwm_out    (pwm_out)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Floor division written out explicitly rather than as a shift
  function automatic int model_duty(input int osc, input int env, input int valid, input int dith);
    int e, p, sh, d;
    e = valid ? env : 0;
    p = (osc - 128) * e;
    if (p >= 0) sh = p / 64;
    else        sh = -((-p + 63) / 64);
    d = 128 + sh + dith;
    if (d < 0)   d = 0;
    if (d > 255) d = 255;
    return d;
  endfunction

  task automatic sb_push(input int osc, input int env, input int valid);
    int dith, fb;
    dith = 0;
`ifdef VCA_DITHER_EN
    dith   = lfsr_m & 1;
    fb     = ((lfsr_m >> 7) ^ (lfsr_m >> 5) ^ (lfsr_m >> 4) ^ (lfsr_m >> 3)) & 1;
    lfsr_m = ((lfsr_m << 1) | fb) & 255;
`else
    fb = 0;
`endif
    exp_q.push_back(model_duty(osc, env, valid, dith + fb * 0));
  endtask

  task automatic sb_reset();
    exp_q.delete();
    lfsr_m = 1;
    exp_q.push_back(128);
    sb_push(0, 0, 0);
  endtask

  // Entered at the negedge where cnt == 1; leaves at the next such negedge
  task automatic run_period(input int t_osc, input int t_env, input int t_valid, input bit toggle);
    int exp, highs;
    highs = 0;
    if (exp_q.size() == 0) begin
      check_val("sb_empty", 0, 1);
      exp = -1;
    end else begin
      exp = exp_q.pop_front();
    end
    check_val("duty_out", int'(duty_out), exp);
    for (int i = 0; i < 256; i++) begin
      highs += int'(pwm_out);
      check_val("sample_tick", int'(sample_tick), (i == 254) ? 1 : 0);
      if (toggle && i != 254) osc_in = (i % 2 != 0) ? 8'd0 : 8'd255;
      else                    osc_in = 8'(t_osc);
      env_in    = 6'(t_env);
      env_valid = t_valid[0];
      if (i == 254) sb_push(t_osc, t_env, t_valid);
      @(negedge clk);
    end
    check_val("pwm_high_cnt", highs, exp);
  endtask

  initial begin
    rstn      = 1'b0;
    osc_in    = 8'd128;
    env_in    = 6'd0;
    env_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_pwm_out", int'(pwm_out), 0);
    check_val("rst_duty_out", int'(duty_out), 128);
    check_val("rst_sample_tick", int'(sample_tick), 0);
    rstn = 1'b1;
    sb_reset();
    @(negedge clk);

    repeat (3) run_period(255, 63, 1, 1'b0);
    repeat (99) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_val("midrst_pwm_out", int'(pwm_out), 0);
    check_val("midrst_duty_out", int'(duty_out), 128);
    check_val("midrst_sample_tick", int'(sample_tick), 0);
    osc_in    = 8'd128;
    env_in    = 6'd0;
    env_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    sb_reset();
    @(negedge clk);

    repeat (2) run_period(128, 0, 0, 1'b0);
    repeat (3) run_period(255, 63, 1, 1'b0);
    repeat (3) run_period(0, 63, 1, 1'b0);
    repeat (3) run_period(255, 63, 0, 1'b0);
    repeat (3) run_period(255, 63, 1, 1'b0);
    repeat (3) run_period(127, 1, 1, 1'b0);
    repeat (3) run_period(129, 1, 1, 1'b0);
    repeat (3) run_period(0, 63, 1, 1'b1);
    repeat (3) run_period(255, 63, 1, 1'b1);
    repeat (8) run_period(255, 0, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
